// File: rtl/conv_pkg.sv
// Shared definitions for the conv datapath: word format, default window size, window indexing.
package conv_pkg;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int SIZE = 7;

    typedef logic [N-1:0] word_t;

    // Flattened row-major position of window element (r, c).
    function automatic int win_idx(input int r, input int c, input int size);
        return r * size + c;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Row delay line: output is the input from DEPTH enabled cycles earlier.
// Read-before-write on the shared pointer; storage is deliberately not reset.
module line_delay #(
    parameter int N     = 32,
    parameter int DEPTH = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] dout_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, SIZE x SIZE row-major windows out, one cycle after the completing pixel.
// Single output slot: a held window stalls input via pix_ready = !win_valid || win_ready.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int SIZE  = conv_pkg::SIZE,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int N     = conv_pkg::N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pix_in,
    input  logic         pix_valid,
    output logic         pix_ready,
    output logic [N-1:0] win_out [SIZE*SIZE],
    output logic         win_valid,
    input  logic         win_ready,
    output logic         win_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic [N-1:0]  win_q [SIZE*SIZE];
    logic [N-1:0]  win_d [SIZE*SIZE];
    logic [N-1:0]  tap [SIZE];

    logic accept, col_end, row_end, complete;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col_q == CW'(IMG_W - 1));
    assign row_end   = (row_q == RW'(IMG_H - 1));
    assign complete  = accept && (row_q >= RW'(SIZE - 1)) && (col_q >= CW'(SIZE - 1));

    // tap[k] is the current pixel delayed by k image rows.
    assign tap[0] = pix_in;
    for (genvar k = 0; k < SIZE - 1; k++) begin : g_lines
        line_delay #(
            .N     (N),
            .DEPTH (IMG_W)
        ) u_line (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (accept),
            .din_i  (tap[k]),
            .dout_o (tap[k+1])
        );
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Top window row is fed by the deepest tap so it holds the oldest image row.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE - 1; c++) begin
                    win_d[win_idx(r, c, SIZE)] = win_q[win_idx(r, c + 1, SIZE)];
                end
                win_d[win_idx(r, SIZE - 1, SIZE)] = tap[SIZE-1-r];
            end
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        if (complete) begin
            win_valid_d = 1'b1;
            win_last_d  = row_end && col_end;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int i = 0; i < SIZE * SIZE; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_q       <= win_d;
        end
    end

    assign win_out   = win_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

    typedef logic [9*32-1:0] w9_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a_pix_in;
    logic        a_pix_valid, a_pix_ready, a_win_valid, a_win_ready, a_win_last;
    logic [31:0] a_win_out [9];

    logic [31:0] b_pix_in;
    logic        b_pix_valid, b_pix_ready, b_win_valid, b_win_ready, b_win_last;
    logic [31:0] b_win_out [49];

    int tests = 0;
    int fails = 0;

    conv_window_gen #(.SIZE(3), .IMG_W(5), .IMG_H(4), .N(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_in(a_pix_in), .pix_valid(a_pix_valid),
        .pix_ready(a_pix_ready), .win_out(a_win_out), .win_valid(a_win_valid),
        .win_ready(a_win_ready), .win_last(a_win_last)
    );

    conv_window_gen #(.SIZE(7), .IMG_W(28), .IMG_H(28), .N(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_in(b_pix_in), .pix_valid(b_pix_valid),
        .pix_ready(b_pix_ready), .win_out(b_win_out), .win_valid(b_win_valid),
        .win_ready(b_win_ready), .win_last(b_win_last)
    );

    function automatic w9_t pack_a();
        w9_t v;
        for (int i = 0; i < 9; i++) v[i*32 +: 32] = a_win_out[i];
        return v;
    endfunction

    // Window k of a 5x4 frame whose pixel value is base + raster index.
    function automatic w9_t exp_win(input int base, input int k);
        w9_t v;
        int wr, wc;
        wr = k / 3;
        wc = k % 3;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*32 +: 32] = 32'(base + (wr + r) * 5 + wc + c);
        return v;
    endfunction

    w9_t q_win[$];
    bit  q_last[$];

    always @(negedge clk) begin
        if (a_win_valid && a_win_ready) begin
            q_win.push_back(pack_a());
            q_last.push_back(a_win_last);
        end
    end

    int          b_cnt = 0;
    int          b_lastcnt = 0;
    logic        b_last484 = 1'b0;
    logic [31:0] b_w1 [49];
    logic [31:0] b_w484 [49];
    logic [31:0] img [784];

    always @(negedge clk) begin
        if (b_win_valid && b_win_ready) begin
            b_cnt++;
            if (b_win_last) b_lastcnt++;
            if (b_cnt == 1) b_w1 = b_win_out;
            if (b_cnt == 484) begin
                b_w484    = b_win_out;
                b_last484 = b_win_last;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input w9_t obs, input w9_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int start, input int base);
        w9_t w;
        bit  l;
        for (int k = 0; k < 6; k++) begin
            w = (start + k < q_win.size()) ? q_win[start+k] : '0;
            l = (start + k < q_last.size()) ? q_last[start+k] : 1'b0;
            chk_win($sformatf("%s_win%0d", tag, k), w, exp_win(base, k));
            chk($sformatf("%s_last%0d", tag, k), 32'(l), 32'(k == 5));
        end
    endtask

    task automatic push(input logic [31:0] v);
        int n = 0;
        a_pix_in    = v;
        a_pix_valid = 1'b1;
        @(negedge clk);
        while (!a_pix_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("push_ready", 32'(a_pix_ready), 32'd1);
        @(posedge clk);
        #1;
        a_pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        a_pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 20; i++) push(32'(base + i));
    endtask

    initial begin
        rst_n = 1'b0;
        a_pix_in = '0; a_pix_valid = 1'b0; a_win_ready = 1'b1;
        b_pix_in = '0; b_pix_valid = 1'b0; b_win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", 32'(a_win_valid), 32'd0);
        chk("rst_win_last", 32'(a_win_last), 32'd0);
        chk("rst_pix_ready", 32'(a_pix_ready), 32'd1);
        chk_win("rst_win_out", pack_a(), '0);
        rst_n = 1'b1;

        // Full frame with the consumer always ready.
        for (int i = 0; i < 12; i++) push(32'(i));
        chk("s1_no_win_before_12", 32'(a_win_valid), 32'd0);
        push(32'd12);
        chk("s1_valid_after_12", 32'(a_win_valid), 32'd1);
        chk_win("s1_first_win_now", pack_a(), exp_win(0, 0));
        chk("s1_first_not_last", 32'(a_win_last), 32'd0);
        for (int i = 13; i < 20; i++) push(32'(i));
        chk("s1_last_valid", 32'(a_win_valid), 32'd1);
        chk("s1_last_flag", 32'(a_win_last), 32'd1);
        idle(2);
        chk("s1_drained_valid", 32'(a_win_valid), 32'd0);
        chk("s1_drained_last", 32'(a_win_last), 32'd0);
        chk("s1_count", 32'(q_win.size()), 32'd6);
        check_frame("s1", 0, 0);

        // Random input bubbles.
        q_win.delete(); q_last.delete();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            push(32'(i));
        end
        idle(3);
        chk("s2_count", 32'(q_win.size()), 32'd6);
        check_frame("s2", 0, 0);

        // Output backpressure holds the first window and stalls input.
        q_win.delete(); q_last.delete();
        a_win_ready = 1'b0;
        for (int i = 0; i < 13; i++) push(32'(i));
        a_pix_in    = 32'd13;
        a_pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("s3_stall_ready%0d", i), 32'(a_pix_ready), 32'd0);
            chk_win($sformatf("s3_hold_win%0d", i), pack_a(), exp_win(0, 0));
            @(posedge clk);
            #1;
        end
        a_win_ready = 1'b1;
        for (int i = 13; i < 20; i++) push(32'(i));
        idle(3);
        chk("s3_count", 32'(q_win.size()), 32'd6);
        check_frame("s3", 0, 0);

        // Two back-to-back frames.
        q_win.delete(); q_last.delete();
        push_frame(0);
        push_frame(100);
        idle(3);
        chk("s4_count", 32'(q_win.size()), 32'd12);
        check_frame("s4f1", 0, 0);
        check_frame("s4f2", 6, 100);

        // Reset after pixel 13, then a fresh frame.
        q_win.delete(); q_last.delete();
        for (int i = 0; i < 14; i++) push(32'(i));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("s5_rst_valid", 32'(a_win_valid), 32'd0);
        chk("s5_rst_last", 32'(a_win_last), 32'd0);
        chk("s5_rst_ready", 32'(a_pix_ready), 32'd1);
        chk_win("s5_rst_win", pack_a(), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) push(32'(200 + i));
        chk("s5_no_early_win", 32'(q_win.size()), 32'd2);
        chk("s5_no_early_valid", 32'(a_win_valid), 32'd0);
        for (int i = 12; i < 20; i++) push(32'(200 + i));
        idle(3);
        chk("s5_count", 32'(q_win.size()), 32'd8);
        check_frame("s5", 2, 200);

        // Full-size 7x7 over 28x28 with random data.
        for (int i = 0; i < 784; i++) img[i] = $urandom;
        for (int i = 0; i < 784; i++) begin
            b_pix_in    = img[i];
            b_pix_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        b_pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("s6_count", 32'(b_cnt), 32'd484);
        chk("s6_last_count", 32'(b_lastcnt), 32'd1);
        chk("s6_last_on_484", 32'(b_last484), 32'd1);
        begin
            int bad1 = 0;
            int bad484 = 0;
            for (int r = 0; r < 7; r++)
                for (int c = 0; c < 7; c++) begin
                    if (b_w1[r*7+c] !== img[r*28+c]) bad1++;
                    if (b_w484[r*7+c] !== img[(21+r)*28+21+c]) bad484++;
                end
            chk("s6_win1_bad_elems", 32'(bad1), 32'd0);
            chk("s6_win484_bad_elems", 32'(bad484), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
